// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and helpers for the multi-port register file
package reg_file_pkg;

  typedef enum logic {CLEAR, READY} rf_state_t;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int MAX_PORTS         = 8;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;
  typedef logic [MAX_PORTS-1:0]         port_mask_t;

  // One-hot of the highest-index set bit: the youngest write port wins.
  function automatic port_mask_t highest_hit(input port_mask_t hits);
    logic found;
    highest_hit = '0;
    found       = 1'b0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (hits[i] && !found) begin
        highest_hit[i] = 1'b1;
        found          = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register busy bits for hazard detection
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     ready_i,
  input  logic                                     claim_i,
  input  logic [ADDRESS_WIDTH-1:0]                 claim_addr_i,
  input  logic [WRITE_PORTS-1:0]                   wr_ok_i,
  input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0]  rd_addr_i,
  input  logic [READ_PORTS-1:0]                    bypass_hit_i,
  output logic [READ_PORTS-1:0]                    rd_busy_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] busy;

  // Writes retire a pending producer; a same-cycle claim is newer and overrides.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
    end else if (ready_i) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_ok_i[w]) busy[wr_addr_i[w]] <= 1'b0;
      end
      if (claim_i && !(ZERO_REG != 0 && claim_addr_i == '0)) begin
        busy[claim_addr_i] <= 1'b1;
      end
    end
  end

  // A forwarded write this cycle already satisfies the reader.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_busy_o[p] = ready_i && busy[rd_addr_i[p]] && !bypass_hit_i[p]
                     && !(ZERO_REG != 0 && rd_addr_i[p] == '0);
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with bypass, scoreboard and clear sweep
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 1,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  output logic                                     ready_o,
  input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0]  rd_addr_i,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]     rd_data_o,
  output logic [READ_PORTS-1:0]                    rd_busy_o,
  input  logic [WRITE_PORTS-1:0]                   we_i,
  input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wr_data_i,
  input  logic                                     claim_i,
  input  logic [ADDRESS_WIDTH-1:0]                 claim_addr_i
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  rf_state_t                state;
  logic [ADDRESS_WIDTH-1:0] sweep_cnt;
  logic [WRITE_PORTS-1:0]   wr_ok;
  logic [READ_PORTS-1:0]    bypass_hit;
  port_mask_t               hits;
  port_mask_t               sel;

  // Writes only count once the file is usable; the hardwired zero entry drops them.
  always_comb begin
    for (int w = 0; w < WRITE_PORTS; w++) begin
      wr_ok[w] = ready_o && we_i[w] && !(ZERO_REG != 0 && wr_addr_i[w] == '0);
    end
  end

  // Sweep FSM: zero one entry per cycle, then stay usable until the next reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (sweep_cnt == ADDRESS_WIDTH'(DEPTH - 1)) begin
            state   <= READY;
            ready_o <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        READY:   state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage: sweep clears entries, later write ports overwrite earlier ones.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == CLEAR) begin
        mem[sweep_cnt] <= '0;
      end else begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (wr_ok[w]) mem[wr_addr_i[w]] <= wr_data_i[w];
        end
      end
    end
  end

  // Read muxes: zero register, then youngest matching write, then storage.
  always_comb begin
    hits       = '0;
    sel        = '0;
    bypass_hit = '0;
    rd_data_o  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      hits = '0;
      for (int w = 0; w < WRITE_PORTS; w++) begin
        hits[w] = wr_ok[w] && (wr_addr_i[w] == rd_addr_i[p]);
      end
      sel           = highest_hit(hits);
      bypass_hit[p] = (BYPASS != 0) && (|sel);
      rd_data_o[p]  = mem[rd_addr_i[p]];
      if (BYPASS != 0) begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (sel[w]) rd_data_o[p] = wr_data_i[w];
        end
      end
      if (!ready_o || (ZERO_REG != 0 && rd_addr_i[p] == '0)) begin
        rd_data_o[p] = '0;
      end
    end
  end

  reg_file_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .READ_PORTS    (READ_PORTS),
    .WRITE_PORTS   (WRITE_PORTS),
    .ZERO_REG      (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ready_i      (ready_o),
    .claim_i      (claim_i),
    .claim_addr_i (claim_addr_i),
    .wr_ok_i      (wr_ok),
    .wr_addr_i    (wr_addr_i),
    .rd_addr_i    (rd_addr_i),
    .bypass_hit_i (bypass_hit),
    .rd_busy_o    (rd_busy_o)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int RP    = 3;
  localparam int WP    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   ready;
  logic [RP-1:0][AW-1:0]  rd_addr;
  logic [RP-1:0][DW-1:0]  rd_data;
  logic [RP-1:0]          rd_busy;
  logic [WP-1:0]          we;
  logic [WP-1:0][AW-1:0]  wr_addr;
  logic [WP-1:0][DW-1:0]  wr_data;
  logic                   claim;
  logic [AW-1:0]          claim_addr;

  logic                   ready_nb;
  logic [0:0][AW-1:0]     rd_addr_nb;
  logic [0:0][DW-1:0]     rd_data_nb;
  logic [0:0]             rd_busy_nb;
  logic [0:0]             we_nb;
  logic [0:0][AW-1:0]     wr_addr_nb;
  logic [0:0][DW-1:0]     wr_data_nb;
  logic                   claim_nb;
  logic [AW-1:0]          claim_addr_nb;

  reg_file_mp #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP), .WRITE_PORTS(WP),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_i(claim), .claim_addr_i(claim_addr)
  );

  reg_file_mp #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(1), .WRITE_PORTS(1),
    .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk_i(clk), .rst_i(rst), .ready_o(ready_nb),
    .rd_addr_i(rd_addr_nb), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .we_i(we_nb), .wr_addr_i(wr_addr_nb), .wr_data_i(wr_data_nb),
    .claim_i(claim_nb), .claim_addr_i(claim_addr_nb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural contents, pending producers, cycles since reset.
  logic [DW-1:0] mem_m  [DEPTH];
  logic          busy_m [DEPTH];
  int            since_rst = 0;
  bit            model_on  = 1'b0;

  function automatic logic ready_m();
    return since_rst == DEPTH;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int p);
    logic [DW-1:0] d;
    if (!ready_m() || rd_addr[p] == '0) return '0;
    d = mem_m[rd_addr[p]];
    for (int w = 0; w < WP; w++) begin
      if (we[w] && wr_addr[w] == rd_addr[p]) d = wr_data[w];
    end
    return d;
  endfunction

  function automatic logic exp_busy(input int p);
    if (!ready_m() || rd_addr[p] == '0) return 1'b0;
    for (int w = 0; w < WP; w++) begin
      if (we[w] && wr_addr[w] == rd_addr[p]) return 1'b0;
    end
    return busy_m[rd_addr[p]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      since_rst = 0;
      model_on  = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[i]  = '0;
        busy_m[i] = 1'b0;
      end
    end else if (ready_m()) begin
      for (int w = 0; w < WP; w++) begin
        if (we[w] && wr_addr[w] != '0) begin
          mem_m[wr_addr[w]]  = wr_data[w];
          busy_m[wr_addr[w]] = 1'b0;
        end
      end
      if (claim && claim_addr != '0) busy_m[claim_addr] = 1'b1;
    end else begin
      since_rst++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      #1;
      chk1("model_ready", ready, ready_m());
      for (int p = 0; p < RP; p++) begin
        chk($sformatf("model_rd_data[%0d]", p), rd_data[p], exp_data(p));
        chk1($sformatf("model_rd_busy[%0d]", p), rd_busy[p], exp_busy(p));
      end
    end
  end

  // Called at the negedge where reset has just been released.
  task automatic check_sweep();
    for (int i = 1; i <= 33; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      chk1($sformatf("sweep_ready_c%0d", i), ready, (i == 33));
      chk1($sformatf("sweep_ready_nb_c%0d", i), ready_nb, (i == 33));
    end
  endtask

  initial begin
    rst = 1'b1; we = '0; wr_addr = '0; wr_data = '0; claim = 1'b0; claim_addr = '0;
    rd_addr = '0;
    we_nb = '0; wr_addr_nb = '0; wr_data_nb = '0; rd_addr_nb = '0;
    claim_nb = 1'b0; claim_addr_nb = '0;

    @(negedge clk); rst = 1'b0;
    check_sweep();
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd9; rd_addr[2] = 5'd31;
    #1;
    chk("reset_read_x5", rd_data[0], 32'h0);
    chk("reset_read_x9", rd_data[1], 32'h0);
    chk("reset_read_x31", rd_data[2], 32'h0);

    @(negedge clk);
    we = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
    we_nb = 1'b1; wr_addr_nb[0] = 5'd5; wr_data_nb[0] = 32'hDEADBEEF; rd_addr_nb[0] = 5'd5;
    #1;
    chk("bypass_x5_same", rd_data[0], 32'hDEADBEEF);
    chk("nobypass_x5_same", rd_data_nb[0], 32'h0);
    @(negedge clk); we = '0; we_nb = '0;
    #1;
    chk("storage_x5_next", rd_data[0], 32'hDEADBEEF);
    chk("nobypass_x5_next", rd_data_nb[0], 32'hDEADBEEF);

    @(negedge clk);
    we = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; rd_addr[1] = 5'd7;
    #1; chk("dual_write_bypass_x7", rd_data[1], 32'h22);
    @(negedge clk); we = '0;
    #1; chk("dual_write_storage_x7", rd_data[1], 32'h22);

    @(negedge clk);
    we = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFF; rd_addr[2] = 5'd0;
    #1; chk("x0_same", rd_data[2], 32'h0);
    @(negedge clk); we = '0;
    #1; chk("x0_next", rd_data[2], 32'h0);

    @(negedge clk); claim = 1'b1; claim_addr = 5'd3; rd_addr[0] = 5'd3;
    #1; chk1("claim_x3_same", rd_busy[0], 1'b0);
    @(negedge clk); claim = 1'b0;
    #1; chk1("claim_x3_next", rd_busy[0], 1'b1);
    @(negedge clk); we = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
    #1; chk1("write_x3_bypass_busy", rd_busy[0], 1'b0);
    chk("write_x3_bypass_data", rd_data[0], 32'h33);
    @(negedge clk); we = '0;
    #1; chk1("write_x3_busy_after", rd_busy[0], 1'b0);
    @(negedge clk); we = 2'b01; wr_data[0] = 32'h34; claim = 1'b1;
    #1; chk1("claim_write_x3_same", rd_busy[0], 1'b0);
    @(negedge clk); we = '0; claim = 1'b0;
    #1; chk1("claim_write_x3_after", rd_busy[0], 1'b1);

    @(negedge clk); we = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
    @(negedge clk); we = '0; rd_addr[1] = 5'd9;
    #1; chk("x9_before_reset", rd_data[1], 32'h99);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_sweep();
    #1; chk("x9_after_reset", rd_data[1], 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); rd_addr[0] = AW'(i);
      #1;
      chk1($sformatf("post_reset_busy_x%0d", i), rd_busy[0], 1'b0);
      chk($sformatf("post_reset_data_x%0d", i), rd_data[0], 32'h0);
    end

    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int w = 0; w < WP; w++) begin
        we[w]      = 1'($urandom_range(0, 1));
        wr_addr[w] = AW'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      claim      = ($urandom_range(0, 3) == 0);
      claim_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < RP; p++) begin
        rd_addr[p] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                 : AW'($urandom_range(0, 7));
      end
    end

    @(negedge clk); we = '0; claim = 1'b0;
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
